id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID→EX pipeline register and load-use hazard controller.
- Captures decoded instructions and bypassed rs1/rs2 operands from two register-bypass instances and presents them to EX under a valid/ready handshake.
- Consumes each bypass instance's load_flag and inserts exactly one bubble per load-use hazard.
- Drives the EX-stage writeback tag (ex_rw_en/addr) back to the bypass network, gated by valid.

Parameters:
- DATA_WIDTH, 32, operand/PC/immediate width
- REG_WIDTH, 5, register address width
- ALU_OP_WIDTH, 8, ALU opcode width
- LSU_OP_WIDTH, 4, LSU opcode width; bit 2 == 0 denotes a load

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  redirect from EX/branch; kills the ID-side and EX-side entries
- id_valid  in  1  ID holds a valid instruction
- id_ready  out  1  this stage accepts the ID instruction this cycle
- id_pc  in  DATA_WIDTH  instruction PC
- id_rs1_data  in  DATA_WIDTH  bypassed rs1 operand
- id_rs2_data  in  DATA_WIDTH  bypassed rs2 operand
- id_rs1_load_flag  in  1  load_flag from the rs1 bypass instance
- id_rs2_load_flag  in  1  load_flag from the rs2 bypass instance
- id_imm  in  DATA_WIDTH  immediate
- id_alu_op  in  ALU_OP_WIDTH  ALU opcode
- id_lsu_op  in  LSU_OP_WIDTH  LSU opcode
- id_rw_en  in  1  instruction writes rd
- id_rw_addr  in  REG_WIDTH  rd
- ex_valid  out  1  EX register holds a valid instruction
- ex_ready  in  1  EX accepts this cycle
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  DATA_WIDTH  registered copies
- ex_alu_op  out  ALU_OP_WIDTH  registered copy
- ex_lsu_op  out  LSU_OP_WIDTH  registered copy
- ex_rw_en  out  1  registered rw_en AND ex_valid; feeds bypass ex_rw_en
- ex_rw_addr  out  REG_WIDTH  registered rd; feeds bypass ex_rw_addr
- bubble_cnt  out  32  count of load-use bubbles inserted, wraps

Behaviour:
- Reset (rst_n low, asynchronous): ex_valid=0, ex_rw_en=0, all data/op/addr registers=0, bubble_cnt=0, FSM=EMPTY. id_ready=0 while rst_n is low.
- Signal definitions:
  - hazard = id_valid & (id_rs1_load_flag | id_rs2_load_flag)
  - adv = ~ex_valid | ex_ready (the EX register can be overwritten)
- id_ready = adv & ~hazard & ~flush. This path is combinational; it is the only comb path from inputs to outputs.
- FSM states and per-edge actions, in priority order:
  - flush=1: ex_valid←0, FSM→EMPTY. The ID instruction is not captured. bubble_cnt is unchanged. Flush beats hazard and beats ex_ready=0.
  - adv & id_valid & ~hazard: capture all id_* fields, ex_valid←1, FSM→FULL. 1-cycle latency from ID to EX.
  - adv & hazard: ex_valid←0 (bubble), FSM→BUBBLE, bubble_cnt←bubble_cnt+1. Payload registers hold their previous values.
  - adv & ~id_valid: ex_valid←0, FSM→EMPTY.
  - ~adv (FULL & ~ex_ready): all registers hold; the EX output stays stable until accepted.
- BUBBLE is an ordinary empty state.
  - Because ex_rw_en drops with ex_valid, the bypass load_flag deasserts on the next cycle and the load data is forwarded from MEM.
  - If a hazard is still reported in BUBBLE (e.g. a second load in MEM is not flagged), insert another bubble. There is no hard limit, and each bubble is counted.
- A hazard is never evaluated while ~adv, because the load is still in EX and no bubble is needed yet. bubble_cnt increments only on an edge where a bubble is actually inserted.
- Simultaneous ex_ready=1 and new capture: the old entry is consumed and the new one is written in the same edge (full throughput, no dead cycle).
- ex_rw_en is always 0 when ex_valid=0, so a bubble or flushed entry never forwards.
- bubble_cnt wraps from 32'hFFFF_FFFF to 0.
- No X on outputs after reset; payload registers need not be cleared on flush.

Test Plan:
- Reset mid-stream: FULL with ex_pc=32'h1C00_0004, assert rst_n=0 asynchronously between edges → ex_valid=0, ex_rw_en=0, bubble_cnt=0 immediately, without waiting for a clock edge.
- Back-to-back flow: id_valid=1 for 4 cycles with pc 0x100/0x104/0x108/0x10C, ex_ready=1 → ex_pc follows 1 cycle later each cycle, and id_ready=1 throughout.
- Load-use: load to r5 in EX with id_rs1_load_flag=1 for 1 cycle → id_ready=0; next cycle ex_valid=0 and ex_rw_en=0; the following cycle captures the dependent instruction with bubble_cnt=1.
- Backpressure: FULL with ex_ready=0 for 3 cycles and id_valid=1 → id_ready=0, EX outputs unchanged; first cycle ex_ready=1 → new instruction captured the same edge.
- Flush priority: flush=1 with hazard=1 and ex_ready=0 → next cycle ex_valid=0, bubble_cnt unchanged, and id_ready=0 during the flush cycle.
- Counter wrap: force 2^32−1 via hazard sequence or preload → next bubble yields bubble_cnt=0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID->EX stage bundle: ID-side request/operands, EX-side registered outputs.
// slave = the stage itself, master = the surrounding pipeline (ID/bypass/EX).
interface id_ex_stage_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_WIDTH    = 5,
    parameter int ALU_OP_WIDTH = 8,
    parameter int LSU_OP_WIDTH = 4
) ();
    logic                    flush;
    logic                    id_valid;
    logic                    id_ready;
    logic [DATA_WIDTH-1:0]   id_pc;
    logic [DATA_WIDTH-1:0]   id_rs1_data;
    logic [DATA_WIDTH-1:0]   id_rs2_data;
    logic                    id_rs1_load_flag;
    logic                    id_rs2_load_flag;
    logic [DATA_WIDTH-1:0]   id_imm;
    logic [ALU_OP_WIDTH-1:0] id_alu_op;
    logic [LSU_OP_WIDTH-1:0] id_lsu_op;
    logic                    id_rw_en;
    logic [REG_WIDTH-1:0]    id_rw_addr;
    logic                    ex_valid;
    logic                    ex_ready;
    logic [DATA_WIDTH-1:0]   ex_pc;
    logic [DATA_WIDTH-1:0]   ex_rs1_data;
    logic [DATA_WIDTH-1:0]   ex_rs2_data;
    logic [DATA_WIDTH-1:0]   ex_imm;
    logic [ALU_OP_WIDTH-1:0] ex_alu_op;
    logic [LSU_OP_WIDTH-1:0] ex_lsu_op;
    logic                    ex_rw_en;
    logic [REG_WIDTH-1:0]    ex_rw_addr;
    logic [31:0]             bubble_cnt;

    modport slave (
        input  flush, id_valid, id_pc, id_rs1_data, id_rs2_data,
        input  id_rs1_load_flag, id_rs2_load_flag, id_imm,
        input  id_alu_op, id_lsu_op, id_rw_en, id_rw_addr, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
        output ex_imm, ex_alu_op, ex_lsu_op, ex_rw_en, ex_rw_addr,
        output bubble_cnt
    );

    modport master (
        output flush, id_valid, id_pc, id_rs1_data, id_rs2_data,
        output id_rs1_load_flag, id_rs2_load_flag, id_imm,
        output id_alu_op, id_lsu_op, id_rw_en, id_rw_addr, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data,
        input  ex_imm, ex_alu_op, ex_lsu_op, ex_rw_en, ex_rw_addr,
        input  bubble_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with load-use bubble insertion.
// Ports: clk, rst_n (async, active low), bus (id_ex_stage_if.slave).
module id_ex_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_WIDTH    = 5,
    parameter int ALU_OP_WIDTH = 8,
    parameter int LSU_OP_WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        BUBBLE = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, rs1_q, rs2_q, imm_q;
    logic [ALU_OP_WIDTH-1:0] alu_op_q;
    logic [LSU_OP_WIDTH-1:0] lsu_op_q;
    logic                    rw_en_q;
    logic [REG_WIDTH-1:0]    rw_addr_q;
    logic [31:0]             bubble_cnt_q, bubble_cnt_d;

    logic ex_valid;
    logic hazard;
    logic adv;
    logic cap;

    assign ex_valid = (state_q == FULL);
    assign hazard   = bus.id_valid &
                      (bus.id_rs1_load_flag | bus.id_rs2_load_flag);
    assign adv      = ~ex_valid | bus.ex_ready;

    // rst_n gate keeps ID stalled while the stage is held in reset
    assign bus.id_ready = rst_n & adv & ~hazard & ~bus.flush;

    // Arms are made mutually exclusive so flush wins over everything
    always_comb begin
        state_d      = state_q;
        bubble_cnt_d = bubble_cnt_q;
        cap          = 1'b0;
        unique case (1'b1)
            bus.flush: begin
                state_d = EMPTY;
            end
            ~bus.flush & adv & bus.id_valid & ~hazard: begin
                state_d = FULL;
                cap     = 1'b1;
            end
            ~bus.flush & adv & hazard: begin
                state_d      = BUBBLE;
                bubble_cnt_d = bubble_cnt_q + 32'd1;
            end
            ~bus.flush & adv & ~bus.id_valid: begin
                state_d = EMPTY;
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            bubble_cnt_q <= '0;
            pc_q         <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            imm_q        <= '0;
            alu_op_q     <= '0;
            lsu_op_q     <= '0;
            rw_en_q      <= 1'b0;
            rw_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            bubble_cnt_q <= bubble_cnt_d;
            if (cap) begin
                pc_q      <= bus.id_pc;
                rs1_q     <= bus.id_rs1_data;
                rs2_q     <= bus.id_rs2_data;
                imm_q     <= bus.id_imm;
                alu_op_q  <= bus.id_alu_op;
                lsu_op_q  <= bus.id_lsu_op;
                rw_en_q   <= bus.id_rw_en;
                rw_addr_q <= bus.id_rw_addr;
            end
        end
    end

    assign bus.ex_valid    = ex_valid;
    assign bus.ex_pc       = pc_q;
    assign bus.ex_rs1_data = rs1_q;
    assign bus.ex_rs2_data = rs2_q;
    assign bus.ex_imm      = imm_q;
    assign bus.ex_alu_op   = alu_op_q;
    assign bus.ex_lsu_op   = lsu_op_q;
    // A bubble or flushed entry must never look like a forwarding source
    assign bus.ex_rw_en    = rw_en_q & ex_valid;
    assign bus.ex_rw_addr  = rw_addr_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.flush            = 1'b0;
        bus.id_valid         = 1'b0;
        bus.id_pc            = '0;
        bus.id_rs1_data      = '0;
        bus.id_rs2_data      = '0;
        bus.id_rs1_load_flag = 1'b0;
        bus.id_rs2_load_flag = 1'b0;
        bus.id_imm           = '0;
        bus.id_alu_op        = '0;
        bus.id_lsu_op        = '0;
        bus.id_rw_en         = 1'b0;
        bus.id_rw_addr       = '0;
        bus.ex_ready         = 1'b1;

        // Reset state
        #2;
        chk1("rst_ex_valid", bus.ex_valid, 1'b0);
        chk1("rst_ex_rw_en", bus.ex_rw_en, 1'b0);
        chk("rst_bubble_cnt", bus.bubble_cnt, 32'd0);
        chk("rst_ex_pc", bus.ex_pc, 32'd0);
        chk1("rst_id_ready", bus.id_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Back-to-back flow, one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            bus.id_valid    = 1'b1;
            bus.id_pc       = 32'h100 + 32'(4 * i);
            bus.id_rs1_data = 32'hA000 + 32'(i);
            bus.id_imm      = 32'hB000 + 32'(i);
            #1;
            chk1("b2b_id_ready", bus.id_ready, 1'b1);
            tick();
            chk1("b2b_ex_valid", bus.ex_valid, 1'b1);
            chk("b2b_ex_pc", bus.ex_pc, 32'h100 + 32'(4 * i));
            chk("b2b_ex_rs1", bus.ex_rs1_data, 32'hA000 + 32'(i));
            chk("b2b_ex_imm", bus.ex_imm, 32'hB000 + 32'(i));
        end
        bus.id_valid = 1'b0;
        tick();
        chk1("idle_ex_valid", bus.ex_valid, 1'b0);

        // Load to r5 enters EX
        bus.id_valid   = 1'b1;
        bus.id_pc      = 32'h200;
        bus.id_lsu_op  = 4'b0000;
        bus.id_rw_en   = 1'b1;
        bus.id_rw_addr = 5'd5;
        bus.id_alu_op  = 8'h3C;
        tick();
        chk1("ld_ex_valid", bus.ex_valid, 1'b1);
        chk1("ld_ex_rw_en", bus.ex_rw_en, 1'b1);
        chk("ld_ex_rw_addr", {27'd0, bus.ex_rw_addr}, 32'd5);
        chk("ld_ex_alu_op", {24'd0, bus.ex_alu_op}, 32'h3C);

        // Dependent instruction sees the load flag for one cycle
        bus.id_pc            = 32'h204;
        bus.id_lsu_op        = 4'b0100;
        bus.id_rw_addr       = 5'd6;
        bus.id_rs1_load_flag = 1'b1;
        #1;
        chk1("lu_id_ready", bus.id_ready, 1'b0);
        tick();
        chk1("lu_bubble_valid", bus.ex_valid, 1'b0);
        chk1("lu_bubble_rw_en", bus.ex_rw_en, 1'b0);
        chk("lu_bubble_cnt", bus.bubble_cnt, 32'd1);
        chk("lu_payload_hold", bus.ex_pc, 32'h200);
        bus.id_rs1_load_flag = 1'b0;
        #1;
        chk1("lu_id_ready2", bus.id_ready, 1'b1);
        tick();
        chk1("lu_dep_valid", bus.ex_valid, 1'b1);
        chk("lu_dep_pc", bus.ex_pc, 32'h204);
        chk("lu_dep_cnt", bus.bubble_cnt, 32'd1);
        chk("lu_dep_rw_addr", {27'd0, bus.ex_rw_addr}, 32'd6);

        // Backpressure: EX holds for 3 cycles
        bus.ex_ready = 1'b0;
        bus.id_pc    = 32'h300;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("bp_id_ready", bus.id_ready, 1'b0);
            tick();
            chk1("bp_ex_valid", bus.ex_valid, 1'b1);
            chk("bp_ex_pc", bus.ex_pc, 32'h204);
            chk1("bp_ex_rw_en", bus.ex_rw_en, 1'b1);
        end
        bus.ex_ready = 1'b1;
        #1;
        chk1("bp_release_ready", bus.id_ready, 1'b1);
        tick();
        chk("bp_new_pc", bus.ex_pc, 32'h300);
        chk1("bp_new_valid", bus.ex_valid, 1'b1);

        // Flush beats hazard and backpressure
        bus.ex_ready         = 1'b0;
        bus.id_pc            = 32'h400;
        bus.id_rs2_load_flag = 1'b1;
        bus.flush            = 1'b1;
        #1;
        chk1("fl_id_ready", bus.id_ready, 1'b0);
        tick();
        chk1("fl_ex_valid", bus.ex_valid, 1'b0);
        chk1("fl_ex_rw_en", bus.ex_rw_en, 1'b0);
        chk("fl_bubble_cnt", bus.bubble_cnt, 32'd1);
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;

        // Hazard persists in BUBBLE: each cycle adds a bubble
        tick();
        chk("rb_cnt1", bus.bubble_cnt, 32'd2);
        chk1("rb_valid1", bus.ex_valid, 1'b0);
        tick();
        chk("rb_cnt2", bus.bubble_cnt, 32'd3);

        // Counter wrap
        force dut.bubble_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.bubble_cnt_q;
        #1;
        chk("wr_preload", bus.bubble_cnt, 32'hFFFF_FFFF);
        tick();
        chk("wr_wrap", bus.bubble_cnt, 32'd0);
        tick();
        chk("wr_after", bus.bubble_cnt, 32'd1);
        bus.id_rs2_load_flag = 1'b0;

        // Reset mid-stream while FULL
        bus.id_pc = 32'h1C00_0004;
        tick();
        chk("mr_ex_pc", bus.ex_pc, 32'h1C00_0004);
        chk1("mr_full", bus.ex_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("mr_ex_valid", bus.ex_valid, 1'b0);
        chk1("mr_ex_rw_en", bus.ex_rw_en, 1'b0);
        chk("mr_bubble_cnt", bus.bubble_cnt, 32'd0);
        chk("mr_ex_pc_clr", bus.ex_pc, 32'd0);
        chk1("mr_id_ready", bus.id_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
